// File: rtl/flag_tracker.sv
// ---------------------------------------------------------------------------
// flag_tracker
//
// Purpose:
//   Per-level flag collection tracker for the Rally-X playfield. Each frame
//   the player car box is tested against the current level's flag boxes.
//   The lowest-index visible overlapping flag becomes the candidate. A flag
//   is collected once the same candidate has overlapped for DEBOUNCE
//   consecutive frames. The collected count drives level advance and the
//   win screen. Per-flag visibility drives the sprite/colour mapper.
//
// Optional feature:
//   Define FLAG_SCORE_EN to add a 16-bit saturating score register and the
//   `score` output port. Without the macro there is no score port, no score
//   register and no score adder.
//
// Parameters:
//   NUM_FLAGS - flags per level (the coordinate table holds 4 per level)
//   FLAG_HALF - flag half-width in pixels (square flag box)
//   DEBOUNCE  - consecutive overlapping frames needed to collect (1..3)
//
// Ports:
//   frame_clk    in   1          frame clock, all state on its rising edge
//   Reset_n      in   1          synchronous active-low reset
//   BallX        in   11         player centre X (0..1279)
//   BallY        in   11         player centre Y (0..959)
//   BallS        in   11         player half-size
//   levelindex   in   2          0 = level 0, 1..3 = level 1
//   flagreset    in   1          restore all flags and clear the count
//   GameOver     in   1          freeze the tracker until Reset_n
//   flagcount    out  4          flags collected this level
//   flag_visible out  NUM_FLAGS  bit i high while flag i is uncollected
//   flag_pulse   out  1          one-cycle strobe on a collection edge
//   score        out  16         (FLAG_SCORE_EN only) accumulated score
// ---------------------------------------------------------------------------
module flag_tracker #(
    parameter int NUM_FLAGS = 4,
    parameter int FLAG_HALF = 8,
    parameter int DEBOUNCE  = 2
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  logic [10:0]          BallX,
    input  logic [10:0]          BallY,
    input  logic [10:0]          BallS,
    input  logic [1:0]           levelindex,
    input  logic                 flagreset,
    input  logic                 GameOver,
    output logic [3:0]           flagcount,
    output logic [NUM_FLAGS-1:0] flag_visible,
    output logic                 flag_pulse
`ifdef FLAG_SCORE_EN
    ,
    output logic [15:0]          score
`endif
);

    localparam int         IDX_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;
    localparam logic [1:0] DEB_LIMIT = 2'(DEBOUNCE);
    localparam logic [3:0] CNT_MAX   = 4'(NUM_FLAGS);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    // Flag X coordinate table, indexed by {level, flag index}.
    function automatic logic [10:0] flag_x(input logic lvl, input logic [1:0] idx);
        logic [10:0] x;
        case ({lvl, idx})
            3'b000:  x = 11'd200;
            3'b001:  x = 11'd1000;
            3'b010:  x = 11'd300;
            3'b011:  x = 11'd1100;
            3'b100:  x = 11'd640;
            3'b101:  x = 11'd160;
            3'b110:  x = 11'd1120;
            3'b111:  x = 11'd640;
            default: x = 11'd0;
        endcase
        return x;
    endfunction

    // Flag Y coordinate table, indexed by {level, flag index}.
    function automatic logic [10:0] flag_y(input logic lvl, input logic [1:0] idx);
        logic [10:0] y;
        case ({lvl, idx})
            3'b000:  y = 11'd200;
            3'b001:  y = 11'd160;
            3'b010:  y = 11'd800;
            3'b011:  y = 11'd760;
            3'b100:  y = 11'd160;
            3'b101:  y = 11'd480;
            3'b110:  y = 11'd480;
            3'b111:  y = 11'd800;
            default: y = 11'd0;
        endcase
        return y;
    endfunction

    // |a - b| on zero-extended 12-bit signed operands; world coordinates
    // never wrap, so the magnitude always fits in 12 bits.
    function automatic logic [11:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] d;
        logic [11:0] m;
        d = {1'b0, a} - {1'b0, b};
        if (d[11]) begin
            m = 12'd0 - d;
        end else begin
            m = d;
        end
        return m;
    endfunction

    // Registered state
    state_t               state_q;
    logic [1:0]           lvl_q;
    logic [3:0]           count_q;
    logic [NUM_FLAGS-1:0] vis_q;
    logic                 pulse_q;
    logic [1:0]           streak_q;
    logic                 cand_valid_q;
    logic [IDX_W-1:0]     cand_idx_q;
`ifdef FLAG_SCORE_EN
    logic [15:0]          score_q;
    logic [16:0]          score_sum_s;
    logic [15:0]          score_d;
`endif

    // Combinational next-state helpers
    logic                 lvl_sel_s;
    logic [11:0]          limit_s;
    logic [NUM_FLAGS-1:0] hit_s;
    logic                 cand_found_s;
    logic [IDX_W-1:0]     cand_idx_s;
    logic [1:0]           streak_d;
    logic                 collect_s;
    logic [3:0]           count_d;
    logic                 restart_s;

    assign lvl_sel_s = (levelindex != 2'd0);
    assign limit_s   = {1'b0, BallS} + 12'(FLAG_HALF);
    assign restart_s = flagreset || (levelindex != lvl_q);

    // Per-flag box overlap against the current level's table (strict less-than).
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if ((abs_diff(BallX, flag_x(lvl_sel_s, 2'(i))) < limit_s) &&
                (abs_diff(BallY, flag_y(lvl_sel_s, 2'(i))) < limit_s)) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
    end

    // Candidate select: scan high-to-low so the lowest visible hit wins.
    always_comb begin
        cand_found_s = 1'b0;
        cand_idx_s   = '0;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (hit_s[i] && vis_q[i]) begin
                cand_found_s = 1'b1;
                cand_idx_s   = IDX_W'(i);
            end else begin
                cand_found_s = cand_found_s;
            end
        end
    end

    // Debounce streak, collection decision and saturating count increment.
    always_comb begin
        streak_d = 2'd0;
        if (!cand_found_s) begin
            streak_d = 2'd0;
        end else if (cand_valid_q && (cand_idx_q == cand_idx_s)) begin
            streak_d = streak_q + 2'd1;
        end else begin
            streak_d = 2'd1;
        end
        collect_s = cand_found_s && (streak_d == DEB_LIMIT);
        if (count_q < CNT_MAX) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

`ifdef FLAG_SCORE_EN
    // Score award is 100 x the post-collection count, saturating at 16 bits.
    always_comb begin
        score_sum_s = {1'b0, score_q} + (17'(count_d) * 17'd100);
        if (score_sum_s[16]) begin
            score_d = 16'hFFFF;
        end else begin
            score_d = score_sum_s[15:0];
        end
    end
`endif

    // Tracker FSM with registered outputs; GameOver outranks restart,
    // restart outranks collection.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q      <= ST_ACTIVE;
            lvl_q        <= 2'd0;
            count_q      <= 4'd0;
            vis_q        <= '1;
            pulse_q      <= 1'b0;
            streak_q     <= 2'd0;
            cand_valid_q <= 1'b0;
            cand_idx_q   <= '0;
`ifdef FLAG_SCORE_EN
            score_q      <= 16'd0;
`endif
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (GameOver) begin
                        state_q <= ST_FROZEN;
                        pulse_q <= 1'b0;
                    end else if (restart_s) begin
                        // Restore happens on the edge that leaves CLEAR;
                        // here only the pending debounce is dropped.
                        state_q      <= ST_CLEAR;
                        lvl_q        <= levelindex;
                        pulse_q      <= 1'b0;
                        streak_q     <= 2'd0;
                        cand_valid_q <= 1'b0;
                    end else if (collect_s) begin
                        vis_q[cand_idx_s] <= 1'b0;
                        count_q           <= count_d;
                        pulse_q           <= 1'b1;
                        streak_q          <= 2'd0;
                        cand_valid_q      <= 1'b0;
`ifdef FLAG_SCORE_EN
                        score_q           <= score_d;
`endif
                    end else begin
                        pulse_q      <= 1'b0;
                        streak_q     <= streak_d;
                        cand_valid_q <= cand_found_s;
                        cand_idx_q   <= cand_idx_s;
                    end
                end
                ST_CLEAR: begin
                    if (GameOver) begin
                        state_q <= ST_FROZEN;
                        pulse_q <= 1'b0;
                    end else begin
                        state_q      <= ST_ACTIVE;
                        lvl_q        <= levelindex;
                        count_q      <= 4'd0;
                        vis_q        <= '1;
                        pulse_q      <= 1'b0;
                        streak_q     <= 2'd0;
                        cand_valid_q <= 1'b0;
                    end
                end
                ST_FROZEN: begin
                    // Held until Reset_n; the strobe stays low.
                    state_q <= ST_FROZEN;
                    pulse_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_ACTIVE;
                    pulse_q      <= 1'b0;
                    streak_q     <= 2'd0;
                    cand_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign flagcount    = count_q;
    assign flag_visible = vis_q;
    assign flag_pulse   = pulse_q;
`ifdef FLAG_SCORE_EN
    assign score        = score_q;
`endif

endmodule

// File: tb/tb_flag_tracker.sv
module tb_flag_tracker;

    logic        frame_clk;
    logic        Reset_n;
    logic [10:0] BallX;
    logic [10:0] BallY;
    logic [10:0] BallS;
    logic [1:0]  levelindex;
    logic        flagreset;
    logic        GameOver;
    logic [3:0]  flagcount;
    logic [3:0]  flag_visible;
    logic        flag_pulse;
`ifdef FLAG_SCORE_EN
    logic [15:0] score;
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    flag_tracker #(.NUM_FLAGS(4), .FLAG_HALF(8), .DEBOUNCE(2)) dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .BallX       (BallX),
        .BallY       (BallY),
        .BallS       (BallS),
        .levelindex  (levelindex),
        .flagreset   (flagreset),
        .GameOver    (GameOver),
        .flagcount   (flagcount),
        .flag_visible(flag_visible),
        .flag_pulse  (flag_pulse)
`ifdef FLAG_SCORE_EN
        ,
        .score       (score)
`endif
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] cnt, input logic [3:0] vis,
                           input logic pls);
        chk({tag, ".count"}, {28'd0, flagcount}, {28'd0, cnt});
        chk({tag, ".vis"}, {28'd0, flag_visible}, {28'd0, vis});
        chk({tag, ".pulse"}, {31'd0, flag_pulse}, {31'd0, pls});
    endtask

    task automatic chk_score(input string tag, input logic [15:0] exp);
`ifdef FLAG_SCORE_EN
        chk({tag, ".score"}, {16'd0, score}, {16'd0, exp});
`else
        if (exp == 16'hFFFF) $display("note: %s", tag);
`endif
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic car(input logic [10:0] x, input logic [10:0] y);
        BallX = x;
        BallY = y;
    endtask

    initial begin
        Reset_n    = 1'b0;
        BallS      = 11'd16;
        levelindex = 2'd0;
        flagreset  = 1'b0;
        GameOver   = 1'b0;
        car(11'd640, 11'd480);
        step();
        step();
        Reset_n = 1'b1;
        chk_out("reset", 4'd0, 4'b1111, 1'b0);
        chk_score("reset", 16'd0);

        // Flag 0 of level 0, held for three frames.
        car(11'd200, 11'd200);
        step(); chk_out("f0.e1", 4'd0, 4'b1111, 1'b0);
        step(); chk_out("f0.e2", 4'd1, 4'b1110, 1'b1);
        chk_score("f0.e2", 16'd100);
        step(); chk_out("f0.e3", 4'd1, 4'b1110, 1'b0);

        // Interrupted overlap on flag 2 (edges of the box) never collects.
        car(11'd323, 11'd800);
        step(); chk_out("blip1", 4'd1, 4'b1110, 1'b0);
        car(11'd640, 11'd480);
        step(); chk_out("gap", 4'd1, 4'b1110, 1'b0);
        car(11'd300, 11'd777);
        step(); chk_out("blip2", 4'd1, 4'b1110, 1'b0);
        // Exactly BallS+FLAG_HALF away is not an overlap.
        car(11'd324, 11'd800);
        step(); step(); chk_out("bound.x", 4'd1, 4'b1110, 1'b0);
        car(11'd276, 11'd824);
        step(); step(); chk_out("bound.xy", 4'd1, 4'b1110, 1'b0);

        // Collect flags 2, 1, 3 of level 0.
        car(11'd300, 11'd800);
        step(); step(); chk_out("f2", 4'd2, 4'b1010, 1'b1);
        car(11'd1000, 11'd160);
        step(); step(); chk_out("f1", 4'd3, 4'b1000, 1'b1);
        car(11'd1100, 11'd760);
        step(); chk_out("f3.e1", 4'd3, 4'b1000, 1'b0);
        step(); chk_out("f3.e2", 4'd4, 4'b0000, 1'b1);
        chk_score("all4", 16'd1000);

        // Level change: hold on the first edge, restore on the next.
        car(11'd640, 11'd480);
        levelindex = 2'd1;
        step(); chk_out("lvl.e1", 4'd4, 4'b0000, 1'b0);
        step(); chk_out("lvl.e2", 4'd0, 4'b1111, 1'b0);
        chk_score("lvl.keep", 16'd1000);
        car(11'd640, 11'd160);
        step(); step(); chk_out("l1f0", 4'd1, 4'b1110, 1'b1);
        chk_score("l1f0", 16'd1100);

        // flagreset pulse with the car away.
        car(11'd640, 11'd480);
        flagreset = 1'b1;
        step(); chk_out("fr.e1", 4'd1, 4'b1110, 1'b0);
        flagreset = 1'b0;
        step(); chk_out("fr.e2", 4'd0, 4'b1111, 1'b0);

        // flagreset on the debounce-completing edge, then held high.
        car(11'd160, 11'd480);
        step(); chk_out("frc.a", 4'd0, 4'b1111, 1'b0);
        flagreset = 1'b1;
        step(); chk_out("frc.b", 4'd0, 4'b1111, 1'b0);
        step(); chk_out("frc.c", 4'd0, 4'b1111, 1'b0);
        step(); chk_out("frc.d", 4'd0, 4'b1111, 1'b0);
        flagreset = 1'b0;
        step(); chk_out("frc.e", 4'd0, 4'b1111, 1'b0);
        step(); chk_out("frc.f", 4'd0, 4'b1111, 1'b0);
        step(); chk_out("frc.g", 4'd1, 4'b1101, 1'b1);
        chk_score("frc.g", 16'd1200);

        // GameOver freezes everything, even with overlap and flagreset.
        car(11'd1120, 11'd480);
        GameOver = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out("frozen", 4'd1, 4'b1101, 1'b0);
        end
        flagreset = 1'b1;
        step(); step(); chk_out("frozen.fr", 4'd1, 4'b1101, 1'b0);
        chk_score("frozen", 16'd1200);

        // Reset_n exits FROZEN.
        flagreset = 1'b0;
        Reset_n   = 1'b0;
        step(); chk_out("rst2", 4'd0, 4'b1111, 1'b0);
        chk_score("rst2", 16'd0);
        GameOver   = 1'b0;
        levelindex = 2'd0;
        Reset_n    = 1'b1;

        // Reset in the middle of a debounce discards the streak.
        car(11'd200, 11'd200);
        step(); chk_out("mid.e1", 4'd0, 4'b1111, 1'b0);
        Reset_n = 1'b0;
        step(); chk_out("mid.rst", 4'd0, 4'b1111, 1'b0);
        Reset_n = 1'b1;
        step(); chk_out("mid.e2", 4'd0, 4'b1111, 1'b0);
        step(); chk_out("mid.e3", 4'd1, 4'b1110, 1'b1);
        chk_score("mid.e3", 16'd100);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
